// File: rtl/issue_queue_ooo.sv
// Out-of-order issue queue: compacting age-ordered storage, register scoreboard with
// writeback wakeup, oldest-ready select into a registered issue stage. Optional flush port: IQ_FLUSH_EN.
module issue_queue_ooo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6,
    parameter int REG_W  = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IQ_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [DATA_W-1:0] d_pc,
    input  logic [DATA_W-1:0] d_sigext,
    input  logic [OPC_W-1:0]  d_opcode,
    input  logic [REG_W-1:0]  d_inst1,
    input  logic [REG_W-1:0]  d_inst2,
    input  logic [REG_W-1:0]  d_inst3,
    input  logic              d_v1,
    input  logic              d_v2,
    input  logic              d_vd,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    output logic              e_valid,
    input  logic              e_ready,
    output logic [DATA_W-1:0] e_pc,
    output logic [DATA_W-1:0] e_sigext,
    output logic [OPC_W-1:0]  e_opcode,
    output logic [REG_W-1:0]  e_inst1,
    output logic [REG_W-1:0]  e_inst2,
    output logic [REG_W-1:0]  e_inst3,
    output logic              e_vd,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int NREG  = 2 ** REG_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  dst;
        logic              v1;
        logic              v2;
        logic              vd;
        logic              p1;
        logic              p2;
    } entry_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // d_ready depends only on occupancy; e_* hold stable while e_valid && !e_ready.

    entry_t            q      [DEPTH];
    entry_t            woke   [DEPTH];
    entry_t            q_n    [DEPTH];
    entry_t            new_ent;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_n;
    logic [DEPTH-1:0]  slot_ready;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              stage_load;
    logic              enq;
    logic              deq;
    logic [CNT_W-1:0]  enq_pos;
    logic [CNT_W-1:0]  count_n;
    logic              flush_i;

`ifdef IQ_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign d_ready    = !full;
    assign enq        = d_valid && d_ready;
    assign stage_load = !e_valid || e_ready;
    assign deq        = stage_load && sel_found;
    assign enq_pos    = deq ? (count - CNT_W'(1)) : count;
    assign count_n    = count + CNT_W'(enq) - CNT_W'(deq);

    // Readiness uses registered pending bits only: a wakeup becomes visible one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_ready[i] = (CNT_W'(i) < count) &&
                            (!q[i].v1 || !q[i].p1) && (!q[i].v2 || !q[i].p2);
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = q[i];
            if (wb_valid && q[i].src1 == wb_reg) woke[i].p1 = 1'b0;
            if (wb_valid && q[i].src2 == wb_reg) woke[i].p2 = 1'b0;
        end
    end

    always_comb begin
        new_ent        = '0;
        new_ent.pc     = d_pc;
        new_ent.imm    = d_sigext;
        new_ent.opcode = d_opcode;
        new_ent.src1   = d_inst1;
        new_ent.src2   = d_inst2;
        new_ent.dst    = d_inst3;
        new_ent.v1     = d_v1;
        new_ent.v2     = d_v2;
        new_ent.vd     = d_vd;
        new_ent.p1     = d_v1 && busy[d_inst1] && !(wb_valid && wb_reg == d_inst1);
        new_ent.p2     = d_v2 && busy[d_inst2] && !(wb_valid && wb_reg == d_inst2);
    end

    // Slots at and above the selected one take their younger neighbour; the enqueue then
    // lands just past the surviving entries.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int nxt;
            nxt = (i < DEPTH - 1) ? i + 1 : i;
            if (deq && int'(sel_idx) <= i) q_n[i] = woke[nxt];
            else                           q_n[i] = woke[i];
            if (enq && CNT_W'(i) == enq_pos) q_n[i] = new_ent;
        end
    end

    // Clear on writeback first so a same-cycle new producer of that register keeps it busy.
    always_comb begin
        busy_n = busy;
        if (wb_valid) busy_n[wb_reg] = 1'b0;
        if (enq && d_vd && d_inst3 != '0) busy_n[d_inst3] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            busy     <= '0;
            e_valid  <= 1'b0;
            e_pc     <= '0;
            e_sigext <= '0;
            e_opcode <= '0;
            e_inst1  <= '0;
            e_inst2  <= '0;
            e_inst3  <= '0;
            e_vd     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (flush_i) begin
            count   <= '0;
            busy    <= '0;
            e_valid <= 1'b0;
        end else begin
            count <= count_n;
            busy  <= busy_n;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
            if (stage_load) begin
                e_valid <= sel_found;
                if (sel_found) begin
                    e_pc     <= q[sel_idx].pc;
                    e_sigext <= q[sel_idx].imm;
                    e_opcode <= q[sel_idx].opcode;
                    e_inst1  <= q[sel_idx].src1;
                    e_inst2  <= q[sel_idx].src2;
                    e_inst3  <= q[sel_idx].dst;
                    e_vd     <= q[sel_idx].vd;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed bench for issue_queue_ooo: program-order issue, dependency wakeup, full/stall,
// same-cycle wakeup at enqueue, r0 handling, and mid-stream reset.
module tb_issue_queue_ooo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 6;
    localparam int REG_W  = 5;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [DATA_W-1:0] IMM_MASK = 32'hFFFF_0000;

    logic              clk;
    logic              rst;
    logic              d_valid;
    logic              d_ready;
    logic [DATA_W-1:0] d_pc;
    logic [DATA_W-1:0] d_sigext;
    logic [OPC_W-1:0]  d_opcode;
    logic [REG_W-1:0]  d_inst1;
    logic [REG_W-1:0]  d_inst2;
    logic [REG_W-1:0]  d_inst3;
    logic              d_v1;
    logic              d_v2;
    logic              d_vd;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic              e_valid;
    logic              e_ready;
    logic [DATA_W-1:0] e_pc;
    logic [DATA_W-1:0] e_sigext;
    logic [OPC_W-1:0]  e_opcode;
    logic [REG_W-1:0]  e_inst1;
    logic [REG_W-1:0]  e_inst2;
    logic [REG_W-1:0]  e_inst3;
    logic              e_vd;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    issue_queue_ooo #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .OPC_W(OPC_W), .REG_W(REG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_sigext(d_sigext),
        .d_opcode(d_opcode), .d_inst1(d_inst1), .d_inst2(d_inst2), .d_inst3(d_inst3),
        .d_v1(d_v1), .d_v2(d_v2), .d_vd(d_vd),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_sigext(e_sigext),
        .e_opcode(e_opcode), .e_inst1(e_inst1), .e_inst2(e_inst2), .e_inst3(e_inst3),
        .e_vd(e_vd), .full(full), .empty(empty), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // drivers
    task automatic enq(input logic [DATA_W-1:0] pc,
                       input logic v1, input logic [REG_W-1:0] s1,
                       input logic v2, input logic [REG_W-1:0] s2,
                       input logic vd, input logic [REG_W-1:0] d);
        d_valid  = 1'b1;
        d_pc     = pc;
        d_sigext = pc ^ IMM_MASK;
        d_opcode = pc[7:2];
        d_v1 = v1; d_inst1 = s1;
        d_v2 = v2; d_inst2 = s2;
        d_vd = vd; d_inst3 = d;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic wb(input logic [REG_W-1:0] r);
        wb_valid = 1'b1;
        wb_reg   = r;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (empty && !e_valid) done = 1'b1;
            else tick();
        end
        check("idle_reached", done, 1'b1);
    endtask

    // scoreboard: every accepted issue must match the next expected pc in order
    always @(negedge clk) begin
        if (rst && e_valid && e_ready) begin
            check("exp_q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("issue_pc", e_pc, exp_q[0]);
                check("issue_imm", e_sigext, exp_q[0] ^ IMM_MASK);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        d_valid = 0; d_pc = 0; d_sigext = 0; d_opcode = 0;
        d_inst1 = 0; d_inst2 = 0; d_inst3 = 0; d_v1 = 0; d_v2 = 0; d_vd = 0;
        wb_valid = 0; wb_reg = 0; e_ready = 1'b1; rst = 1'b1;

        do_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_e_valid", e_valid, 0);
        check("rst_e_pc", e_pc, 0);
        check("rst_d_ready", d_ready, 1);

        // three independent instructions, program order, 2-cycle latency
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        enq(32'h100, 0, 0, 0, 0, 0, 0);
        check("lat_not_yet", e_valid, 0);
        check("lat_count1", count, 1);
        enq(32'h104, 0, 0, 0, 0, 0, 0);
        check("lat_e_valid", e_valid, 1);
        check("lat_e_pc", e_pc, 32'h100);
        enq(32'h108, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("t1_count0", count, 0);
        check("t1_empty", empty, 1);
        check("t1_e_valid0", e_valid, 0);

        // dependency: C bypasses the stalled B, B follows 2 cycles after wb
        exp_q.push_back(32'h200); exp_q.push_back(32'h208); exp_q.push_back(32'h204);
        enq(32'h200, 0, 0, 0, 0, 1, 5);
        enq(32'h204, 1, 5, 0, 0, 0, 0);
        enq(32'h208, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("dep_b_waiting", count, 1);
        check("dep_stage_idle", e_valid, 0);
        wb(5);
        check("dep_wb_no_bypass", e_valid, 0);
        tick();
        check("dep_b_issued", e_valid, 1);
        check("dep_b_pc", e_pc, 32'h204);
        wait_idle();

        // fill with pending entries, reject when full, release the oldest
        exp_q.push_back(32'h300); exp_q.push_back(32'h304);
        enq(32'h300, 0, 0, 0, 0, 1, 9);
        enq(32'h304, 0, 0, 0, 0, 1, 10);
        enq(32'h310, 1, 9, 0, 0, 0, 0);
        for (int k = 1; k < 8; k++) enq(32'h310 + 4 * k, 1, 10, 0, 0, 0, 0);
        check("fill_count8", count, 8);
        check("fill_full", full, 1);
        check("fill_d_ready0", d_ready, 0);
        enq(32'h3F0, 0, 0, 0, 0, 0, 0);
        check("fill_reject", count, 8);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h310 + 4 * k);
        wb(9);
        check("fill_wb_count8", count, 8);
        tick();
        check("fill_count7", count, 7);
        check("fill_d_ready1", d_ready, 1);
        check("fill_full0", full, 0);
        check("fill_oldest_pc", e_pc, 32'h310);

        // stall the issue stage while the rest are ready
        e_ready = 1'b0;
        wb(10);
        for (int k = 0; k < 4; k++) begin
            check("stall_e_valid", e_valid, 1);
            check("stall_e_pc", e_pc, 32'h310);
            check("stall_count", count, 7);
            tick();
        end
        e_ready = 1'b1;
        tick();
        check("unstall_pc", e_pc, 32'h314);
        check("unstall_count", count, 6);
        wait_idle();

        // wakeup in the enqueue cycle clears the pending bit
        exp_q.push_back(32'h400); exp_q.push_back(32'h404);
        exp_q.push_back(32'h410); exp_q.push_back(32'h414);
        exp_q.push_back(32'h420); exp_q.push_back(32'h424);
        enq(32'h400, 0, 0, 0, 0, 1, 7);
        tick();
        wb_valid = 1'b1; wb_reg = 7;
        enq(32'h404, 1, 7, 0, 0, 0, 0);
        wb_valid = 1'b0;
        check("byp_stage_idle", e_valid, 0);
        tick();
        check("byp_e_valid", e_valid, 1);
        check("byp_e_pc", e_pc, 32'h404);
        // newer producer wins over a same-cycle writeback of the same register
        wb_valid = 1'b1; wb_reg = 8;
        enq(32'h410, 0, 0, 0, 0, 1, 8);
        wb_valid = 1'b0;
        enq(32'h414, 1, 8, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("newer_prod_pending", count, 1);
        check("newer_prod_idle", e_valid, 0);
        wb(8);
        tick();
        check("newer_prod_pc", e_pc, 32'h414);
        wait_idle();
        // r0 is never busy
        enq(32'h420, 0, 0, 0, 0, 1, 0);
        enq(32'h424, 1, 0, 1, 0, 0, 0);
        tick();
        check("r0_e_valid", e_valid, 1);
        check("r0_e_pc", e_pc, 32'h424);
        wait_idle();

        // reset with five queued entries
        exp_q.push_back(32'h500);
        enq(32'h500, 0, 0, 0, 0, 1, 12);
        for (int k = 0; k < 5; k++) enq(32'h510 + 4 * k, 1, 12, 0, 0, 0, 0);
        check("mid_count5", count, 5);
        do_reset();
        check("mid_rst_count", count, 0);
        check("mid_rst_e_valid", e_valid, 0);
        check("mid_rst_empty", empty, 1);
        exp_q.push_back(32'h520);
        enq(32'h520, 1, 12, 0, 0, 0, 0);
        tick();
        check("mid_sb_clear_valid", e_valid, 1);
        check("mid_sb_clear_pc", e_pc, 32'h520);
        wait_idle();
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
